// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite bus arbiter: registered grant and ownership tracking,
// burst- and lock-aware re-arbitration, and master-to-shared-bus multiplexing.
module ahb_bus_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned MW          = $clog2(NUM_MASTERS)
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic [NUM_MASTERS-1:0]      HBUSREQ,
    input  logic [NUM_MASTERS-1:0]      HLOCK,
    input  logic [NUM_MASTERS*32-1:0]   M_HADDR,
    input  logic [NUM_MASTERS*2-1:0]    M_HTRANS,
    input  logic [NUM_MASTERS-1:0]      M_HWRITE,
    input  logic [NUM_MASTERS*2-1:0]    M_HSIZE,
    input  logic [NUM_MASTERS*3-1:0]    M_HBURST,
    input  logic [NUM_MASTERS*32-1:0]   M_HWDATA,
    input  logic                        HREADY,
    input  logic                        HRESP,
    output logic [NUM_MASTERS-1:0]      HGRANT,
    output logic [MW-1:0]               HMASTER,
    output logic                        HMASTLOCK,
    output logic [31:0]                 HADDR,
    output logic [1:0]                  HTRANS,
    output logic                        HWRITE,
    output logic [1:0]                  HSIZE,
    output logic [2:0]                  HBURST,
    output logic [31:0]                 HWDATA
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned XW = MW + 1;
    localparam logic [1:0]  TRANS_NONSEQ = 2'b10;
    localparam logic [1:0]  TRANS_SEQ    = 2'b11;

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          grant_idx_q, grant_idx_d;
    logic [MW-1:0]          ptr_q, ptr_d;
    logic [MW-1:0]          hmaster_q, hmaster_d;
    logic [MW-1:0]          hmaster_dp_q, hmaster_dp_d;
    logic                   mastlock_q, mastlock_d;
    logic [CW-1:0]          beat_q, beat_d;

    logic                   nonseq_acc, seq_acc, load_nz, rearb_ok;
    logic [CW-1:0]          load_val;
    logic                   win_found;
    logic [MW-1:0]          win_idx;
    logic [XW-1:0]          cand;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q      <= NUM_MASTERS'(1);
            grant_idx_q  <= '0;
            ptr_q        <= '0;
            hmaster_q    <= '0;
            hmaster_dp_q <= '0;
            mastlock_q   <= 1'b0;
            beat_q       <= '0;
        end else begin
            grant_q      <= grant_d;
            grant_idx_q  <= grant_idx_d;
            ptr_q        <= ptr_d;
            hmaster_q    <= hmaster_d;
            hmaster_dp_q <= hmaster_dp_d;
            mastlock_q   <= mastlock_d;
            beat_q       <= beat_d;
        end
    end

    // Remaining-beat count of the current fixed-length burst; an error aborts it.
    always_comb begin : beat_count
        load_val = '0;
        case (HBURST)
            3'd2, 3'd3: load_val = CW'(3);
            3'd4, 3'd5: load_val = CW'(7);
            3'd6, 3'd7: load_val = CW'(15);
            default:    load_val = '0;
        endcase
        nonseq_acc = HREADY && (HTRANS == TRANS_NONSEQ);
        seq_acc    = HREADY && (HTRANS == TRANS_SEQ);
        load_nz    = nonseq_acc && (load_val != '0);
        beat_d     = beat_q;
        if (HREADY && HRESP) begin
            beat_d = '0;
        end else if (nonseq_acc) begin
            beat_d = load_val;
        end else if (seq_acc && (beat_q != '0)) begin
            beat_d = beat_q - CW'(1);
        end
        rearb_ok = !HLOCK[grant_idx_q] && !load_nz &&
                   ((beat_q == '0) || ((beat_q == CW'(1)) && seq_acc));
    end

    // Circular scan from pointer+1; the last winner is checked last for fairness.
    always_comb begin : arbitrate
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            cand = {1'b0, ptr_q} + XW'(i);
            if (cand >= XW'(NUM_MASTERS)) begin
                cand = cand - XW'(NUM_MASTERS);
            end
            if (!win_found && HBUSREQ[cand[MW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[MW-1:0];
            end
        end
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        if (rearb_ok) begin
            if (win_found) begin
                grant_idx_d = win_idx;
                ptr_d       = win_idx;
            end else begin
                grant_idx_d = '0;
            end
        end
        grant_d = NUM_MASTERS'(1) << grant_idx_d;
    end

    // Ownership advances only on HREADY cycles.
    always_comb begin : ownership
        hmaster_d    = hmaster_q;
        hmaster_dp_d = hmaster_dp_q;
        mastlock_d   = mastlock_q;
        if (HREADY) begin
            hmaster_d    = grant_idx_q;
            hmaster_dp_d = hmaster_q;
            mastlock_d   = HLOCK[grant_idx_q];
        end
    end

    // Master 0 is the default, which also covers unused index codes.
    always_comb begin : bus_mux
        HADDR  = M_HADDR[AW-1:0];
        HTRANS = M_HTRANS[1:0];
        HWRITE = M_HWRITE[0];
        HSIZE  = M_HSIZE[1:0];
        HBURST = M_HBURST[2:0];
        HWDATA = M_HWDATA[DW-1:0];
        for (int unsigned i = 1; i < NUM_MASTERS; i++) begin
            if (hmaster_q == MW'(i)) begin
                HADDR  = M_HADDR[AW*i +: AW];
                HTRANS = M_HTRANS[2*i +: 2];
                HWRITE = M_HWRITE[i];
                HSIZE  = M_HSIZE[2*i +: 2];
                HBURST = M_HBURST[3*i +: 3];
            end
            if (hmaster_dp_q == MW'(i)) begin
                HWDATA = M_HWDATA[DW*i +: DW];
            end
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed testbench for ahb_bus_arbiter with three masters: vector table plus
// hand-written error-abort and asynchronous-reset sequences.
module tb_ahb_bus_arbiter;

    localparam int unsigned N = 3;

    logic            HCLK;
    logic            HRESETn;
    logic [N-1:0]    HBUSREQ, HLOCK;
    logic [N*32-1:0] M_HADDR, M_HWDATA;
    logic [N*2-1:0]  M_HTRANS, M_HSIZE;
    logic [N-1:0]    M_HWRITE;
    logic [N*3-1:0]  M_HBURST;
    logic            HREADY, HRESP;
    logic [N-1:0]    HGRANT;
    logic [1:0]      HMASTER;
    logic            HMASTLOCK;
    logic [31:0]     HADDR, HWDATA;
    logic [1:0]      HTRANS, HSIZE;
    logic            HWRITE;
    logic [2:0]      HBURST;

    ahb_bus_arbiter #(.NUM_MASTERS(N), .MW(2)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE),
        .M_HSIZE(M_HSIZE), .M_HBURST(M_HBURST), .M_HWDATA(M_HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HGRANT(HGRANT), .HMASTER(HMASTER),
        .HMASTLOCK(HMASTLOCK), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic       do_rst;
        logic [2:0] req;
        logic [2:0] lock;
        logic [5:0] trans;
        logic [8:0] burst;
        logic       rdy;
        logic       resp;
        logic [2:0] e_grant;
        logic [1:0] e_master;
        logic       e_lock;
        logic [1:0] e_downer;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] addr_of(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h100;
    endfunction

    function automatic logic [31:0] data_of(input int i);
        return 32'hD000_0000 + 32'(i);
    endfunction

    function automatic void add(input logic r, input logic [2:0] rq, input logic [2:0] lk,
                                input logic [5:0] tr, input logic [8:0] bu, input logic rd,
                                input logic rs, input logic [2:0] eg, input logic [1:0] em,
                                input logic el, input logic [1:0] ed);
        vec_t v;
        v.do_rst = r;  v.req = rq;  v.lock = lk;  v.trans = tr;  v.burst = bu;
        v.rdy = rd;    v.resp = rs; v.e_grant = eg; v.e_master = em;
        v.e_lock = el; v.e_downer = ed;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] rq, input logic [2:0] lk, input logic [5:0] tr,
                         input logic [8:0] bu, input logic rd, input logic rs);
        HBUSREQ = rq; HLOCK = lk; M_HTRANS = tr; M_HBURST = bu; HREADY = rd; HRESP = rs;
    endtask

    task automatic step(input logic [2:0] rq, input logic [2:0] lk, input logic [5:0] tr,
                        input logic [8:0] bu, input logic rd, input logic rs);
        drive(rq, lk, tr, bu, rd, rs);
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic do_reset();
        drive(3'b000, 3'b000, 6'h00, 9'h000, 1'b1, 1'b0);
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        vec_t tv;
        for (int i = 0; i < int'(N); i++) begin
            M_HADDR[32*i +: 32]  = addr_of(i);
            M_HWDATA[32*i +: 32] = data_of(i);
            M_HSIZE[2*i +: 2]    = 2'(i);
        end
        M_HWRITE = 3'b101;
        HRESETn  = 1'b0;
        drive(3'b000, 3'b000, 6'h00, 9'h000, 1'b1, 1'b0);

        // Single request with idle bus, then release and park on master 0
        add(1, 3'b010, 3'b000, 6'h00, 9'h000, 1, 0, 3'b010, 2'd0, 0, 2'd0);
        add(0, 3'b010, 3'b000, 6'h00, 9'h000, 1, 0, 3'b010, 2'd1, 0, 2'd0);
        add(0, 3'b000, 3'b000, 6'h00, 9'h000, 1, 0, 3'b001, 2'd1, 0, 2'd1);
        add(0, 3'b000, 3'b000, 6'h00, 9'h000, 1, 0, 3'b001, 2'd0, 0, 2'd1);
        // Master 0 INCR4 with a wait state on beat 2, master 1 requesting
        add(1, 3'b011, 3'b000, 6'h02, 9'h003, 1, 0, 3'b001, 2'd0, 0, 2'd0);
        add(0, 3'b011, 3'b000, 6'h03, 9'h003, 1, 0, 3'b001, 2'd0, 0, 2'd0);
        add(0, 3'b011, 3'b000, 6'h03, 9'h003, 0, 0, 3'b001, 2'd0, 0, 2'd0);
        add(0, 3'b011, 3'b000, 6'h03, 9'h003, 1, 0, 3'b001, 2'd0, 0, 2'd0);
        add(0, 3'b011, 3'b000, 6'h03, 9'h003, 1, 0, 3'b010, 2'd0, 0, 2'd0);
        add(0, 3'b010, 3'b000, 6'h00, 9'h003, 1, 0, 3'b010, 2'd1, 0, 2'd0);
        // Three masters with SINGLE transfers rotate
        add(1, 3'b111, 3'b000, 6'h2A, 9'h000, 1, 0, 3'b010, 2'd0, 0, 2'd0);
        add(0, 3'b111, 3'b000, 6'h2A, 9'h000, 1, 0, 3'b100, 2'd1, 0, 2'd0);
        add(0, 3'b111, 3'b000, 6'h2A, 9'h000, 1, 0, 3'b001, 2'd2, 0, 2'd1);
        add(0, 3'b111, 3'b000, 6'h2A, 9'h000, 1, 0, 3'b010, 2'd0, 0, 2'd2);
        // Master 1 locked sequence while master 0 requests
        add(1, 3'b010, 3'b010, 6'h00, 9'h000, 1, 0, 3'b010, 2'd0, 0, 2'd0);
        add(0, 3'b011, 3'b010, 6'h08, 9'h000, 1, 0, 3'b010, 2'd1, 1, 2'd0);
        add(0, 3'b011, 3'b010, 6'h08, 9'h000, 1, 0, 3'b010, 2'd1, 1, 2'd1);
        add(0, 3'b011, 3'b010, 6'h08, 9'h000, 1, 0, 3'b010, 2'd1, 1, 2'd1);
        add(0, 3'b001, 3'b000, 6'h00, 9'h000, 1, 0, 3'b001, 2'd1, 0, 2'd1);
        add(0, 3'b001, 3'b000, 6'h00, 9'h000, 1, 0, 3'b001, 2'd0, 0, 2'd1);

        @(negedge HCLK);
        @(negedge HCLK);
        check("reset grant", 32'(HGRANT), 32'h1);
        check("reset hmaster", 32'(HMASTER), 32'h0);
        check("reset mastlock", 32'(HMASTLOCK), 32'h0);
        check("reset haddr", HADDR, addr_of(0));
        check("reset hwdata", HWDATA, data_of(0));
        HRESETn = 1'b1;

        foreach (vecs[k]) begin
            tv = vecs[k];
            if (tv.do_rst) do_reset();
            step(tv.req, tv.lock, tv.trans, tv.burst, tv.rdy, tv.resp);
            check($sformatf("v%0d grant", k), 32'(HGRANT), 32'(tv.e_grant));
            check($sformatf("v%0d hmaster", k), 32'(HMASTER), 32'(tv.e_master));
            check($sformatf("v%0d mastlock", k), 32'(HMASTLOCK), 32'(tv.e_lock));
            check($sformatf("v%0d haddr", k), HADDR, addr_of(int'(tv.e_master)));
            check($sformatf("v%0d hwdata", k), HWDATA, data_of(int'(tv.e_downer)));
            check($sformatf("v%0d hwrite", k), 32'(HWRITE), 32'(M_HWRITE[tv.e_master]));
            check($sformatf("v%0d hsize", k), 32'(HSIZE), 32'(tv.e_master));
            check($sformatf("v%0d htrans", k), 32'(HTRANS),
                  32'(tv.trans[2*int'(tv.e_master) +: 2]));
            check($sformatf("v%0d hburst", k), 32'(HBURST),
                  32'(tv.burst[3*int'(tv.e_master) +: 3]));
        end

        // Error response on beat 2 of a master-0 INCR8 aborts the burst hold
        do_reset();
        step(3'b011, 3'b000, 6'h02, 9'h005, 1'b1, 1'b0);
        check("err nonseq grant", 32'(HGRANT), 32'h1);
        step(3'b011, 3'b000, 6'h03, 9'h005, 1'b1, 1'b0);
        check("err beat1 grant", 32'(HGRANT), 32'h1);
        step(3'b011, 3'b000, 6'h03, 9'h005, 1'b1, 1'b1);
        check("err beat2 hmaster", 32'(HMASTER), 32'h0);
        step(3'b010, 3'b000, 6'h00, 9'h005, 1'b1, 1'b0);
        check("err regrant", 32'(HGRANT), 32'h2);

        // Asynchronous reset in the middle of a master-1 burst
        do_reset();
        step(3'b010, 3'b000, 6'h00, 9'h000, 1'b1, 1'b0);
        step(3'b010, 3'b000, 6'h00, 9'h000, 1'b1, 1'b0);
        check("arst pre hmaster", 32'(HMASTER), 32'h1);
        step(3'b010, 3'b000, 6'h08, 9'h018, 1'b1, 1'b0);
        check("arst pre grant", 32'(HGRANT), 32'h2);
        check("arst pre hwdata", HWDATA, data_of(1));
        drive(3'b010, 3'b000, 6'h0C, 9'h018, 1'b1, 1'b0);
        #2;
        HRESETn = 1'b0;
        #1;
        check("arst grant", 32'(HGRANT), 32'h1);
        check("arst hmaster", 32'(HMASTER), 32'h0);
        check("arst mastlock", 32'(HMASTLOCK), 32'h0);
        check("arst haddr", HADDR, addr_of(0));
        check("arst hwdata", HWDATA, data_of(0));
        @(negedge HCLK);
        HRESETn = 1'b1;
        step(3'b010, 3'b000, 6'h00, 9'h000, 1'b1, 1'b0);
        check("arst counter cleared", 32'(HGRANT), 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Round-robin AHB-Lite bus arbiter that shares the single slave-side bus (decoder, register file, GPIO, response mux) among `NUM_MASTERS` bus masters. It registers grants, tracks address-phase and data-phase ownership, and multiplexes master address/control/write-data onto the shared bus. It blocks re-arbitration during fixed-length bursts and locked sequences, and parks the bus on master 0 when no master requests it.

## Interface
- `NUM_MASTERS`, default 2: number of requesting masters, 2..8.
- `MW`, default `$clog2(NUM_MASTERS)`: width of the master index.

- `HCLK` in 1: bus clock; all state updates on the rising edge.
- `HRESETn` in 1: asynchronous, active-low reset.
- `HBUSREQ` in NUM_MASTERS: per-master bus request.
- `HLOCK` in NUM_MASTERS: per-master lock request.
- `M_HADDR` in NUM_MASTERS*32: master addresses, packed; master i at [32i+31:32i].
- `M_HTRANS` in NUM_MASTERS*2: master transfer types. Encoding: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `M_HWRITE` in NUM_MASTERS: master write flags.
- `M_HSIZE` in NUM_MASTERS*2: master transfer sizes.
- `M_HBURST` in NUM_MASTERS*3: master burst types.
- `M_HWDATA` in NUM_MASTERS*32: master write data.
- `HREADY` in 1: shared ready from the slave mux; broadcast to all masters.
- `HRESP` in 1: shared error response from the slave mux; broadcast to all masters.
- `HGRANT` out NUM_MASTERS: one-hot grant.
- `HMASTER` out MW: index of the address-phase owner.
- `HMASTLOCK` out 1: the current address phase is locked.
- `HADDR` out 32: muxed address, selected by HMASTER.
- `HTRANS` out 2: muxed transfer type, selected by HMASTER.
- `HWRITE` out 1: muxed write flag, selected by HMASTER.
- `HSIZE` out 2: muxed size, selected by HMASTER.
- `HBURST` out 3: muxed burst type, selected by HMASTER.
- `HWDATA` out 32: muxed write data, selected by the data-phase owner.

## Operation
- **Reset values:**
  - HGRANT = 1 (master 0); HMASTER = 0; HMASTLOCK = 0.
  - Internal data-phase owner `hmaster_d` = 0; round-robin pointer = 0; beat counter = 0.
  - Muxed outputs follow master 0 inputs combinationally.
- **Beat counter, 4 bits:**
  - Loaded on an accepted NONSEQ: HREADY=1, HTRANS=NONSEQ, by the owner.
  - HBURST 2/3 (WRAP4/INCR4) loads 3; HBURST 4/5 loads 7; HBURST 6/7 loads 15.
  - SINGLE (0) and INCR (1) load 0.
  - Decrements on each accepted SEQ. BUSY and IDLE leave it unchanged.
  - HRESP=1 with HREADY=1 clears it to 0, since the master is expected to abort the burst.
- **Re-arbitration allowed (`rearb_ok`)** only when all of these hold:
  - The HLOCK bit of the granted master is 0.
  - The current cycle does not load a nonzero count.
  - The counter is 0, or the counter is 1 and the current cycle accepts a SEQ (last beat).
- **Arbitration:**
  - On each edge with `rearb_ok`, HGRANT becomes the first requester found scanning circularly from pointer+1.
  - The pointer updates to that winner.
  - With no requester, HGRANT parks on master 0 and the pointer is unchanged.
  - The current owner still requesting wins only if no other master requests (fairness).
  - When `rearb_ok` is 0, HGRANT holds.
- **Ownership:**
  - On an edge with HREADY=1: HMASTER ← index(HGRANT); `hmaster_d` ← HMASTER; HMASTLOCK ← HLOCK[index(HGRANT)].
  - With HREADY=0, all three hold (wait states freeze ownership).
- **Mux:** address/control come from M_*[HMASTER]; HWDATA comes from M_HWDATA[`hmaster_d`].
- **Out-of-range index** (NUM_MASTERS not a power of 2): select master 0.

## Timing
- **Grant latency:**
  - A request raised before edge N, with the bus idle and `rearb_ok` true, sets HGRANT after edge N.
  - HMASTER switches at the first edge ≥ N+1 with HREADY=1.
  - The new master's address phase follows, one cycle after the grant if HREADY=1.
- **Burst handover:** HGRANT changes at the edge accepting the last SEQ. The old master remains HMASTER for one more HREADY cycle and must drive IDLE.
- **Simultaneous events:**
  - A NONSEQ fixed burst accepted on the same edge as a competing request: the burst wins and HGRANT holds.
  - HRESP with the last beat: the counter goes to 0 and arbitration proceeds normally.
- **Reset mid-operation:** asynchronously forces all reset values; muxed outputs switch to master 0 immediately.

## Test plan
- Reset, no requests:
  - HGRANT=1, HMASTER=0, HMASTLOCK=0.
  - HADDR equals M_HADDR[31:0].
- Master 1 requests, bus idle, HREADY=1:
  - HGRANT=2 after 1 edge, HMASTER=1 after 2 edges.
  - HWDATA from master 1 one cycle later.
- Master 0 runs INCR4 (NONSEQ + 3 SEQ), master 1 requesting throughout:
  - HGRANT stays 1 until the third SEQ is accepted, then becomes 2.
  - Insert HREADY=0 on beat 2: the counter and HMASTER hold.
- Masters 0, 1, 2 request continuously with SINGLE transfers (NUM_MASTERS=3):
  - Grants rotate 0→1→2→0.
  - No master is granted twice while another is waiting.
- Master 1 holds HLOCK=1 with two SINGLE transfers while master 0 requests:
  - HGRANT stays 2 and HMASTLOCK=1 until HLOCK drops.
- HRESP=1, HREADY=1 on beat 2 of a master-0 INCR8 with master 1 requesting:
  - The counter clears and HGRANT=2 on the next edge.
- HRESETn asserted mid-burst:
  - Outputs return to reset values immediately, without waiting for HCLK.
